// File: rtl/signed_shift_add_mult_pkg.sv
// Shared definitions for the signed shift-add multiplier:
// FSM state encoding, default operand width and counter sizing.
package signed_mult_pkg;

    // Default operand width; the product is twice this wide.
    localparam int DEFAULT_N = 8;

    // Multiplier sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    // Iteration counter width: enough bits to count 0..n-1, never below 1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/signed_shift_add_mult_if.sv
// Request/result bundle of the signed shift-add multiplier.
// Handshake: start is a request sampled only while the core is idle
// (busy=0); a start seen while busy=1 is dropped, never queued. done is a
// one-cycle pulse marking the first cycle product is valid; product then
// holds until the sign stage of the next accepted operation.
// state mirrors the internal FSM for observation.
interface signed_shift_add_mult_if
    import signed_mult_pkg::*;
#(
    parameter int N = DEFAULT_N
);
    logic            start;
    logic [N-1:0]    a;
    logic [N-1:0]    b;
    logic            busy;
    logic            done;
    logic [2*N-1:0]  product;
    state_t          state;

    // Requester side: drives operands and start.
    modport master (
        output start, a, b,
        input  busy, done, product, state
    );

    // Multiplier side.
    modport slave (
        input  start, a, b,
        output busy, done, product, state
    );
endinterface

// File: rtl/signed_shift_add_mult_twos_comp_abs.sv
// twos_comp_abs: combinational W-bit magnitude with sign-bit output.
// The value is negated when its own sign bit and i_neg disagree, so
// i_neg=0 yields |i_val|, and for a value known to be non-negative
// i_neg=1 yields its two's-complement negation.
module twos_comp_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_mag,
    output logic         o_sign
);
    logic w_flip;

    assign o_sign = i_val[W-1];
    assign w_flip = i_val[W-1] ^ i_neg;
    // The most negative value maps to itself, which read as unsigned is
    // exactly its magnitude.
    assign o_mag  = w_flip ? (~i_val + W'(1)) : i_val;
endmodule

// File: rtl/signed_shift_add_mult.sv
// signed_shift_add_mult: sequential signed multiplier.
// Operands are converted to sign-magnitude, multiplied by N shift-add
// iterations on the magnitudes, and the sign is applied in a final stage.
// Optional macro SIGNED_MULT_EARLY_TERM_EN: leave the iteration loop as
// soon as the remaining multiplier bits are all zero.
module signed_shift_add_mult
    import signed_mult_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                      clk,
    input  logic                      rst,
    signed_shift_add_mult_if.slave    bus
);
    localparam int CW = cnt_width(N);

    state_t          r_state;
    logic [2*N-1:0]  r_mcand;
    logic [N-1:0]    r_mplier;
    logic [2*N-1:0]  r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_sign;
    logic            r_busy;
    logic            r_done;
    logic [2*N-1:0]  r_product;

    logic [N-1:0]    w_a_mag;
    logic            w_a_sign;
    logic [N-1:0]    w_b_mag;
    logic            w_b_sign;
    logic [2*N-1:0]  w_signed_acc;
    logic            w_acc_sign_unused;
    logic [2*N-1:0]  w_sum;
    logic            w_last;

    twos_comp_abs #(.W(N)) u_abs_a (
        .i_val  (bus.a),
        .i_neg  (1'b0),
        .o_mag  (w_a_mag),
        .o_sign (w_a_sign)
    );

    twos_comp_abs #(.W(N)) u_abs_b (
        .i_val  (bus.b),
        .i_neg  (1'b0),
        .o_mag  (w_b_mag),
        .o_sign (w_b_sign)
    );

    // The accumulated magnitude is at most 2^(2N-2), so its top bit is
    // always clear and this instance acts as a negate-if-r_sign stage.
    // Zero negates to zero, so no negative zero can appear.
    twos_comp_abs #(.W(2*N)) u_apply_sign (
        .i_val  (r_acc),
        .i_neg  (r_sign),
        .o_mag  (w_signed_acc),
        .o_sign (w_acc_sign_unused)
    );

    // Partial-product add; the magnitudes are small enough that 2N bits
    // never overflow.
    assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef SIGNED_MULT_EARLY_TERM_EN
    assign w_last = (r_cnt == CW'(N - 1)) || ((r_mplier >> 1) == '0);
`else
    assign w_last = (r_cnt == CW'(N - 1));
`endif

    // Sequencing FSM with registered busy/done/product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_mcand  <= {{N{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_sign   <= w_a_sign ^ w_b_sign;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= SIGN;
                    end
                end
                SIGN: begin
                    r_product <= w_signed_acc;
                    r_done    <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
    assign bus.state   = r_state;
endmodule

// File: tb/tb_signed_shift_add_mult.sv
// Bench for signed_shift_add_mult: directed vectors at N=8 and N=4 plus a
// short random sweep against a signed reference product.
module tb_signed_shift_add_mult;
    import signed_mult_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    signed_shift_add_mult_if #(.N(8)) if8 ();
    signed_shift_add_mult_if #(.N(4)) if4 ();

    signed_shift_add_mult #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    signed_shift_add_mult #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycle index of done relative to the accepting edge.
    function automatic int exp_lat(input int bval, input int n);
        int mag;
        int h;
        mag = (bval < 0) ? -bval : bval;
        h = 0;
        for (int i = 0; i < 16; i++) if ((mag >> i) & 1) h = i + 1;
`ifdef SIGNED_MULT_EARLY_TERM_EN
        if (h < 1) h = 1;
        return h + 2;
`else
        return n + 2;
`endif
    endfunction

    // One N=8 operation: request, optional operand scramble, wait for done.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_p, input int exp_l, input bit scramble);
        int n;
        bit seen;
        @(negedge clk);
        if8.start = 1'b1; if8.a = a; if8.b = b;
        @(posedge clk); #1;
        if8.start = 1'b0;
        check({tag, "_busy"}, if8.busy, 1);
        if (scramble) begin
            if8.a = ~a;
            if8.b = b ^ 8'h5A;
        end
        seen = 1'b0; n = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (if8.done) seen = 1'b1;
        end
        check({tag, "_lat"}, seen ? n + 1 : 0, exp_l);
        check({tag, "_prod"}, if8.product, exp_p);
        @(posedge clk); #1;
        check({tag, "_idle"}, {if8.busy, if8.done}, 0);
    endtask

    // One N=4 operation.
    task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp_p, input int exp_l);
        int n;
        bit seen;
        @(negedge clk);
        if4.start = 1'b1; if4.a = a; if4.b = b;
        @(posedge clk); #1;
        if4.start = 1'b0;
        seen = 1'b0; n = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (if4.done) seen = 1'b1;
        end
        check({tag, "_lat"}, seen ? n + 1 : 0, exp_l);
        check({tag, "_prod"}, if4.product, exp_p);
        @(posedge clk); #1;
        check({tag, "_idle"}, {if4.busy, if4.done}, 0);
    endtask

    initial begin
        int pa, pb, last, dones;
        bit pulsed;
        logic [7:0] ra, rb;
        logic [3:0] qa, qb;

        if8.start = 1'b0; if8.a = '0; if8.b = '0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", if8.busy, 0);
        check("rst_done", if8.done, 0);
        check("rst_prod", if8.product, 0);
        check("rst_state", if8.state, IDLE);
        check("rst_prod4", if4.product, 0);
        rst = 1'b0;

        // Signs
        run8("s_7xm6",   8'd7,   8'hFA, 16'hFFD6, exp_lat(-6, 8), 1'b0);
        run8("s_m7x6",   8'hF9,  8'd6,  16'hFFD6, exp_lat(6, 8), 1'b0);
        run8("s_m7xm6",  8'hF9,  8'hFA, 16'h002A, exp_lat(-6, 8), 1'b0);
        run8("s_0xm128", 8'd0,   8'h80, 16'h0000, exp_lat(-128, 8), 1'b0);

        // Extremes
        run8("e_m128sq",   8'h80, 8'h80, 16'h4000, exp_lat(-128, 8), 1'b0);
        run8("e_m128x127", 8'h80, 8'h7F, 16'hC080, exp_lat(127, 8), 1'b0);
        run8("e_127sq",    8'h7F, 8'h7F, 16'h3F01, exp_lat(127, 8), 1'b0);

        // Reset in the third CALC cycle of 5*3
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'd5; if8.b = 8'd3;
        @(posedge clk); #1;
        if8.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", if8.busy, 0);
        check("abort_prod", if8.product, 0);
        check("abort_state", if8.state, IDLE);
        @(negedge clk);
        rst = 1'b0;
        pulsed = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if8.done) pulsed = 1'b1;
        end
        check("abort_nodone", pulsed, 0);
        run8("abort_rerun", 8'd5, 8'd3, 16'h000F, exp_lat(3, 8), 1'b0);

        // Operands changed mid-CALC: -100*3 = -300
        run8("opchg", 8'h9C, 8'h03, 16'hFED4, exp_lat(3, 8), 1'b1);

        // start held high: 3*-2 = -6 repeatedly, one result per lat+1 cycles
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'd3; if8.b = 8'hFE;
        last = 0; dones = 0;
        for (int t = 1; t <= 200 && dones < 3; t++) begin
            @(posedge clk); #1;
            if (if8.done) begin
                check("hold_prod", if8.product, 16'hFFFA);
                if (dones == 0) check("hold_first", t, exp_lat(-2, 8));
                else check("hold_gap", t - last, exp_lat(-2, 8) + 1);
                last = t;
                dones++;
                if (dones == 3) if8.start = 1'b0;
            end
        end
        check("hold_count", dones, 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("hold_idle", if8.busy, 0);

`ifdef SIGNED_MULT_EARLY_TERM_EN
        // Early termination latencies
        run8("et_m9x1",   8'hF7, 8'd1,  16'hFFF7, 3, 1'b0);
        run8("et_3x4",    8'd3,  8'd4,  16'h000C, 5, 1'b0);
        run8("et_1xm128", 8'd1,  8'h80, 16'hFF80, 10, 1'b0);
        run8("et_5x0",    8'd5,  8'd0,  16'h0000, 3, 1'b0);
`endif

        // N=4 directed
        run4("n4_m8sq",  4'h8, 4'h8, 8'h40, exp_lat(-8, 4));
        run4("n4_m8x7",  4'h8, 4'h7, 8'hC8, exp_lat(7, 4));
        run4("n4_m3x5",  4'hD, 4'h5, 8'hF1, exp_lat(5, 4));

        // Random sweep against a signed reference product
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            pa = int'($signed(ra));
            pb = int'($signed(rb));
            run8("rnd8", ra, rb, 16'(pa * pb), exp_lat(pb, 8), 1'b0);
        end
        for (int i = 0; i < 200; i++) begin
            qa = 4'($urandom_range(0, 15));
            qb = 4'($urandom_range(0, 15));
            pa = int'($signed(qa));
            pb = int'($signed(qb));
            run4("rnd4", qa, qb, 8'(pa * pb), exp_lat(pb, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
